// File: rtl/cprv_decode_stage_if.sv
// cprv_decode_stage_if: IF/RF/bypass/EX-side signal bundle of the RV64 decode stage.
interface cprv_decode_stage_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 64
);
    logic                   flush_i;
    logic                   valid_id_i;
    logic                   ready_id_o;
    logic [INSTR_WIDTH-1:0] instr_data_id_i;
    logic [DATA_WIDTH-1:0]  pc_id_i;
    logic [4:0]             rs1_addr_rf_o;
    logic [4:0]             rs2_addr_rf_o;
    logic [DATA_WIDTH-1:0]  rs1_data_rf_i;
    logic [DATA_WIDTH-1:0]  rs2_data_rf_i;
    logic                   ex_rd_en_i;
    logic [4:0]             ex_rd_addr_i;
    logic [DATA_WIDTH-1:0]  ex_rd_data_i;
    logic                   ex_is_load_i;
    logic                   wb_rd_en_i;
    logic [4:0]             wb_rd_addr_i;
    logic [DATA_WIDTH-1:0]  wb_rd_data_i;
    logic                   valid_ex_o;
    logic                   ready_ex_i;
    logic [DATA_WIDTH-1:0]  pc_ex_o;
    logic [DATA_WIDTH-1:0]  rs1_data_ex_o;
    logic [DATA_WIDTH-1:0]  rs2_data_ex_o;
    logic [DATA_WIDTH-1:0]  imm_data_ex_o;
    logic [4:0]             rd_addr_ex_o;
    logic                   rd_en_ex_o;
    logic [6:0]             opcode_ex_o;
    logic [2:0]             funct3_ex_o;
    logic [6:0]             funct7_ex_o;
    logic                   mem_r_en_ex_o;
    logic                   mem_w_en_ex_o;
    logic                   illegal_ex_o;

    modport slave (
        input  flush_i, valid_id_i, instr_data_id_i, pc_id_i, rs1_data_rf_i, rs2_data_rf_i,
               ex_rd_en_i, ex_rd_addr_i, ex_rd_data_i, ex_is_load_i,
               wb_rd_en_i, wb_rd_addr_i, wb_rd_data_i, ready_ex_i,
        output ready_id_o, rs1_addr_rf_o, rs2_addr_rf_o, valid_ex_o, pc_ex_o,
               rs1_data_ex_o, rs2_data_ex_o, imm_data_ex_o, rd_addr_ex_o, rd_en_ex_o,
               opcode_ex_o, funct3_ex_o, funct7_ex_o, mem_r_en_ex_o, mem_w_en_ex_o, illegal_ex_o
    );

    modport master (
        output flush_i, valid_id_i, instr_data_id_i, pc_id_i, rs1_data_rf_i, rs2_data_rf_i,
               ex_rd_en_i, ex_rd_addr_i, ex_rd_data_i, ex_is_load_i,
               wb_rd_en_i, wb_rd_addr_i, wb_rd_data_i, ready_ex_i,
        input  ready_id_o, rs1_addr_rf_o, rs2_addr_rf_o, valid_ex_o, pc_ex_o,
               rs1_data_ex_o, rs2_data_ex_o, imm_data_ex_o, rd_addr_ex_o, rd_en_ex_o,
               opcode_ex_o, funct3_ex_o, funct7_ex_o, mem_r_en_ex_o, mem_w_en_ex_o, illegal_ex_o
    );
endinterface

// File: rtl/cprv_decode_stage.sv
// cprv_decode_stage: RV64 ID stage with RF read, EX/WB bypass, load-use stall, full decode and flush.
module cprv_decode_stage #(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 64,
    parameter bit FWD_EN      = 1'b1
) (
    input logic clk,
    input logic rst,
    cprv_decode_stage_if.slave bus
);
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [31:0] instr;
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic is_op, is_imm, is_32, is_imm_32, is_load, is_store, is_branch;
    logic is_jal, is_jalr, is_lui, is_auipc, legal;
    logic uses_rs1, uses_rs2, rd_en;
    logic [DATA_WIDTH-1:0] imm, op1, op2;
    logic ex_hit1, ex_hit2, wb_hit1, wb_hit2, stall, cke;

    assign instr  = bus.instr_data_id_i[31:0];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign is_op     = opcode == OP_OP;
    assign is_imm    = opcode == OP_IMM;
    assign is_32     = opcode == OP_32;
    assign is_imm_32 = opcode == OP_IMM_32;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_branch = opcode == OP_BRANCH;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR;
    assign is_lui    = opcode == OP_LUI;
    assign is_auipc  = opcode == OP_AUIPC;
    // every listed opcode ends in 2'b11, so matching one also validates instr[1:0]
    assign legal = is_op | is_imm | is_32 | is_imm_32 | is_load | is_store | is_branch |
                   is_jal | is_jalr | is_lui | is_auipc;

    assign uses_rs1 = ~(is_jal | is_lui | is_auipc);
    assign uses_rs2 = is_op | is_32 | is_store | is_branch;
    assign rd_en = (is_op | is_imm | is_32 | is_imm_32 | is_load | is_jal | is_jalr |
                    is_lui | is_auipc) & (rd != 5'd0);

    always_comb begin
        imm = '0;
        if (is_imm | is_imm_32 | is_load | is_jalr)
            imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
        else if (is_store)
            imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
        else if (is_branch)
            imm = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        else if (is_lui | is_auipc)
            imm = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
        else if (is_jal)
            imm = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end

    assign bus.rs1_addr_rf_o = rs1;
    assign bus.rs2_addr_rf_o = rs2;

    assign ex_hit1 = bus.ex_rd_en_i && bus.ex_rd_addr_i == rs1 && rs1 != 5'd0;
    assign ex_hit2 = bus.ex_rd_en_i && bus.ex_rd_addr_i == rs2 && rs2 != 5'd0;
    assign wb_hit1 = bus.wb_rd_en_i && bus.wb_rd_addr_i == rs1 && rs1 != 5'd0;
    assign wb_hit2 = bus.wb_rd_en_i && bus.wb_rd_addr_i == rs2 && rs2 != 5'd0;

    assign op1 = rs1 == 5'd0 ? '0 :
                 FWD_EN && ex_hit1 && !bus.ex_is_load_i ? bus.ex_rd_data_i :
                 FWD_EN && wb_hit1 ? bus.wb_rd_data_i : bus.rs1_data_rf_i;
    assign op2 = rs2 == 5'd0 ? '0 :
                 FWD_EN && ex_hit2 && !bus.ex_is_load_i ? bus.ex_rd_data_i :
                 FWD_EN && wb_hit2 ? bus.wb_rd_data_i : bus.rs2_data_rf_i;

    // without bypass any pending write to a used source must drain through the RF first
    assign stall = bus.valid_id_i & (FWD_EN ?
                   bus.ex_is_load_i & ((ex_hit1 & uses_rs1) | (ex_hit2 & uses_rs2)) :
                   ((ex_hit1 | wb_hit1) & uses_rs1) | ((ex_hit2 | wb_hit2) & uses_rs2));

    assign cke = ~bus.valid_ex_o | bus.ready_ex_i;
    assign bus.ready_id_o = cke & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_ex_o    <= 1'b0;
            bus.pc_ex_o       <= '0;
            bus.rs1_data_ex_o <= '0;
            bus.rs2_data_ex_o <= '0;
            bus.imm_data_ex_o <= '0;
            bus.rd_addr_ex_o  <= '0;
            bus.rd_en_ex_o    <= 1'b0;
            bus.opcode_ex_o   <= '0;
            bus.funct3_ex_o   <= '0;
            bus.funct7_ex_o   <= '0;
            bus.mem_r_en_ex_o <= 1'b0;
            bus.mem_w_en_ex_o <= 1'b0;
            bus.illegal_ex_o  <= 1'b0;
        end else begin
            bus.valid_ex_o <= cke ? bus.valid_id_i & ~stall & ~bus.flush_i : bus.valid_ex_o & ~bus.flush_i;
            if (cke) begin
                bus.pc_ex_o       <= bus.pc_id_i;
                bus.rs1_data_ex_o <= op1;
                bus.rs2_data_ex_o <= op2;
                bus.imm_data_ex_o <= imm;
                bus.rd_addr_ex_o  <= rd;
                bus.rd_en_ex_o    <= rd_en & legal;
                bus.opcode_ex_o   <= opcode;
                bus.funct3_ex_o   <= instr[14:12];
                bus.funct7_ex_o   <= instr[31:25];
                bus.mem_r_en_ex_o <= is_load;
                bus.mem_w_en_ex_o <= is_store;
                bus.illegal_ex_o  <= ~legal;
            end
        end
    end
endmodule

// File: tb/tb_cprv_decode_stage.sv
// tb_cprv_decode_stage: directed-vector bench for the RV64 decode stage.
module tb_cprv_decode_stage;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    logic [63:0] rf [32];

    cprv_decode_stage_if bus ();
    cprv_decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.rs1_data_rf_i = rf[bus.rs1_addr_rf_o];
    assign bus.rs2_data_rf_i = rf[bus.rs2_addr_rf_o];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_i = 0; bus.valid_id_i = 0; bus.instr_data_id_i = 0; bus.pc_id_i = 0;
        bus.ex_rd_en_i = 0; bus.ex_rd_addr_i = 0; bus.ex_rd_data_i = 0; bus.ex_is_load_i = 0;
        bus.wb_rd_en_i = 0; bus.wb_rd_addr_i = 0; bus.wb_rd_data_i = 0; bus.ready_ex_i = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        total++; if (bus.valid_ex_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", bus.valid_ex_o); end
        total++; if (bus.imm_data_ex_o !== 64'h0) begin bad++; $display("FAIL reset_imm got=%0h exp=0", bus.imm_data_ex_o); end
        total++; if (bus.pc_ex_o !== 64'h0) begin bad++; $display("FAIL reset_pc got=%0h exp=0", bus.pc_ex_o); end
        total++; if ({bus.rd_addr_ex_o, bus.rd_en_ex_o, bus.opcode_ex_o, bus.funct3_ex_o, bus.funct7_ex_o} !== 23'h0)
            begin bad++; $display("FAIL reset_ctrl got=%0h exp=0", {bus.rd_addr_ex_o, bus.rd_en_ex_o, bus.opcode_ex_o}); end
        total++; if ({bus.mem_r_en_ex_o, bus.mem_w_en_ex_o, bus.illegal_ex_o} !== 3'b000)
            begin bad++; $display("FAIL reset_flags got=%0h exp=0", {bus.mem_r_en_ex_o, bus.mem_w_en_ex_o, bus.illegal_ex_o}); end
        total++; if (bus.ready_id_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h exp=1", bus.ready_id_o); end
        rst = 0;
    endtask

    task automatic test_addi();
        bus.instr_data_id_i = 32'hFFF00293; bus.pc_id_i = 64'h100; bus.valid_id_i = 1;
        #1;
        total++; if (bus.rs1_addr_rf_o !== 5'd0) begin bad++; $display("FAIL addi_rs1_addr got=%0h exp=0", bus.rs1_addr_rf_o); end
        step();
        total++; if (bus.valid_ex_o !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0h exp=1", bus.valid_ex_o); end
        total++; if (bus.imm_data_ex_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL addi_imm got=%0h exp=ffffffffffffffff", bus.imm_data_ex_o); end
        total++; if (bus.rd_addr_ex_o !== 5'd5) begin bad++; $display("FAIL addi_rd got=%0h exp=5", bus.rd_addr_ex_o); end
        total++; if (bus.rd_en_ex_o !== 1'b1) begin bad++; $display("FAIL addi_rd_en got=%0h exp=1", bus.rd_en_ex_o); end
        total++; if (bus.opcode_ex_o !== 7'h13) begin bad++; $display("FAIL addi_opcode got=%0h exp=13", bus.opcode_ex_o); end
        total++; if (bus.pc_ex_o !== 64'h100) begin bad++; $display("FAIL addi_pc got=%0h exp=100", bus.pc_ex_o); end
        total++; if (bus.rs1_data_ex_o !== 64'h0) begin bad++; $display("FAIL addi_x0 got=%0h exp=0", bus.rs1_data_ex_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        for (int i = 1; i <= 4; i++) begin
            ins = {12'(i * 3), 5'd0, 3'd0, 5'(i + 8), 7'h13};
            bus.instr_data_id_i = ins; bus.pc_id_i = 64'(i * 4); bus.valid_id_i = 1;
            #1;
            total++; if (bus.ready_id_o !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%0h exp=1", i, bus.ready_id_o); end
            step();
            total++; if (bus.valid_ex_o !== 1'b1 || bus.imm_data_ex_o !== 64'(i * 3) || bus.rd_addr_ex_o !== 5'(i + 8))
                begin bad++; $display("FAIL b2b_issue[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, bus.valid_ex_o, bus.imm_data_ex_o, bus.rd_addr_ex_o, i * 3, i + 8); end
        end
    endtask

    task automatic test_forward();
        bus.instr_data_id_i = 32'h002081B3; bus.valid_id_i = 1;
        bus.ex_rd_en_i = 1; bus.ex_rd_addr_i = 1; bus.ex_rd_data_i = 64'hAA; bus.ex_is_load_i = 0;
        bus.wb_rd_en_i = 1; bus.wb_rd_addr_i = 1; bus.wb_rd_data_i = 64'hBB;
        step();
        total++; if (bus.rs1_data_ex_o !== 64'hAA) begin bad++; $display("FAIL fwd_ex_over_wb got=%0h exp=aa", bus.rs1_data_ex_o); end
        total++; if (bus.rs2_data_ex_o !== 64'h1002) begin bad++; $display("FAIL fwd_rf_rs2 got=%0h exp=1002", bus.rs2_data_ex_o); end
        bus.wb_rd_addr_i = 2; bus.wb_rd_data_i = 64'h22;
        step();
        total++; if (bus.rs1_data_ex_o !== 64'hAA || bus.rs2_data_ex_o !== 64'h22)
            begin bad++; $display("FAIL fwd_ex_wb got=%0h/%0h exp=aa/22", bus.rs1_data_ex_o, bus.rs2_data_ex_o); end
        total++; if (bus.opcode_ex_o !== 7'h33 || bus.rd_addr_ex_o !== 5'd3 || bus.rd_en_ex_o !== 1'b1)
            begin bad++; $display("FAIL fwd_ctrl got=%0h/%0h/%0h exp=33/3/1", bus.opcode_ex_o, bus.rd_addr_ex_o, bus.rd_en_ex_o); end
        bus.ex_rd_en_i = 0; bus.wb_rd_addr_i = 1; bus.wb_rd_data_i = 64'hBB;
        step();
        total++; if (bus.rs1_data_ex_o !== 64'hBB) begin bad++; $display("FAIL fwd_wb_only got=%0h exp=bb", bus.rs1_data_ex_o); end
        bus.wb_rd_en_i = 0;
    endtask

    task automatic test_load_use();
        bus.instr_data_id_i = 32'h002081B3; bus.valid_id_i = 1;
        bus.ex_rd_en_i = 1; bus.ex_rd_addr_i = 5; bus.ex_is_load_i = 1; bus.ex_rd_data_i = 64'h55;
        #1;
        total++; if (bus.ready_id_o !== 1'b1) begin bad++; $display("FAIL lu_unrelated_ready got=%0h exp=1", bus.ready_id_o); end
        bus.ex_rd_addr_i = 1;
        #1;
        total++; if (bus.ready_id_o !== 1'b0) begin bad++; $display("FAIL lu_ready got=%0h exp=0", bus.ready_id_o); end
        step();
        total++; if (bus.valid_ex_o !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0h exp=0", bus.valid_ex_o); end
        bus.ex_rd_en_i = 0; bus.ex_is_load_i = 0;
        bus.wb_rd_en_i = 1; bus.wb_rd_addr_i = 1; bus.wb_rd_data_i = 64'h77;
        #1;
        total++; if (bus.ready_id_o !== 1'b1) begin bad++; $display("FAIL lu_retry_ready got=%0h exp=1", bus.ready_id_o); end
        step();
        total++; if (bus.valid_ex_o !== 1'b1 || bus.rs1_data_ex_o !== 64'h77)
            begin bad++; $display("FAIL lu_issue got=%0h/%0h exp=1/77", bus.valid_ex_o, bus.rs1_data_ex_o); end
        bus.wb_rd_en_i = 0;
    endtask

    task automatic test_backpressure();
        bus.instr_data_id_i = 32'h00500393; bus.pc_id_i = 64'h200; bus.valid_id_i = 1; bus.ready_ex_i = 1;
        step();
        bus.ready_ex_i = 0; bus.instr_data_id_i = 32'h123452B7; bus.pc_id_i = 64'h204;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.ready_id_o !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%0h exp=0", i, bus.ready_id_o); end
            step();
            total++; if (bus.valid_ex_o !== 1'b1 || bus.rd_addr_ex_o !== 5'd7 || bus.imm_data_ex_o !== 64'h5 || bus.pc_ex_o !== 64'h200)
                begin bad++; $display("FAIL bp_hold[%0d] got=%0h/%0h/%0h/%0h exp=1/7/5/200", i, bus.valid_ex_o, bus.rd_addr_ex_o, bus.imm_data_ex_o, bus.pc_ex_o); end
        end
        bus.flush_i = 1;
        step();
        total++; if (bus.valid_ex_o !== 1'b0) begin bad++; $display("FAIL flush_held got=%0h exp=0", bus.valid_ex_o); end
        total++; if (bus.ready_id_o !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0h exp=1", bus.ready_id_o); end
        bus.ready_ex_i = 1;
        step();
        total++; if (bus.valid_ex_o !== 1'b0) begin bad++; $display("FAIL flush_incoming got=%0h exp=0", bus.valid_ex_o); end
        bus.flush_i = 0;
    endtask

    task automatic test_imm();
        logic [31:0] ins [10] = '{32'h001000EF, 32'hFE000EE3, 32'h123452B7, 32'h0020B423, 32'hFF00B203,
                                  32'h00000013, 32'h00000000, 32'hFFF00290, 32'hFFFFF317, 32'hFFC100E7};
        logic [63:0] eimm [10] = '{64'h800, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234_5000, 64'h8, 64'hFFFF_FFFF_FFFF_FFF0,
                                   64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_FFFC};
        logic [3:0] eflg [10] = '{4'b1000, 4'b0000, 4'b1000, 4'b0010, 4'b1100,
                                  4'b0000, 4'b0001, 4'b0001, 4'b1000, 4'b1000};
        for (int i = 0; i < 10; i++) begin
            bus.instr_data_id_i = ins[i]; bus.valid_id_i = 1;
            step();
            total++; if (bus.imm_data_ex_o !== eimm[i]) begin bad++; $display("FAIL imm[%0d] got=%0h exp=%0h", i, bus.imm_data_ex_o, eimm[i]); end
            total++; if ({bus.rd_en_ex_o, bus.mem_r_en_ex_o, bus.mem_w_en_ex_o, bus.illegal_ex_o} !== eflg[i] || bus.valid_ex_o !== 1'b1)
                begin bad++; $display("FAIL flags[%0d] got=%b/%b exp=%b/1", i, {bus.rd_en_ex_o, bus.mem_r_en_ex_o, bus.mem_w_en_ex_o, bus.illegal_ex_o}, bus.valid_ex_o, eflg[i]); end
        end
        bus.valid_id_i = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 64'h0 : 64'h1000 + 64'(i);
        test_reset();
        test_addi();
        test_back_to_back();
        test_forward();
        test_load_use();
        test_backpressure();
        test_imm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
